// File: rtl/pattern_buf_pkg.sv
// Shared types and sizing helpers for the double-buffered pattern buffer.
// Optional even-parity trailer is enabled by defining PATTERN_BUF_PARITY_EN.
package pattern_buf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    OVERRUN = 2'd2
  } state_t;

`ifdef PATTERN_BUF_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int calc_frame_bits(input int width, input int depth);
    return width * depth;
  endfunction

  // Counter must hold the expected frame length plus one saturation value.
  function automatic int calc_cnt_w(input int frame_bits);
    return $clog2(frame_bits + PARITY_BITS + 2);
  endfunction

endpackage

// File: rtl/pattern_buf_frame_ctl.sv
// Frame controller: bit counter, IDLE/SHIFT/OVERRUN FSM and commit/error decision.
// With PATTERN_BUF_PARITY_EN defined, a trailing even-parity bit is expected and checked.
module pattern_buf_frame_ctl
  import pattern_buf_pkg::*;
#(
  parameter int FRAME_BITS = 256
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ssel,
  input  logic   sin,
  output logic   shift_en,
  output logic   commit,
  output logic   frame_err,
  output state_t state
);

  localparam int EXP_BITS = FRAME_BITS + PARITY_BITS;
  localparam int CNT_W    = calc_cnt_w(FRAME_BITS);
  localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXP_BITS);
  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(EXP_BITS + 1);

  // ssel is a per-cycle valid qualifier for sin; there is no backpressure,
  // a bit is consumed on every sclk edge where ssel is high.
  state_t           state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             err_next;
  logic             frame_ok;

`ifdef PATTERN_BUF_PARITY_EN
  localparam logic [CNT_W-1:0] PAY_C = CNT_W'(FRAME_BITS);
  logic par, par_next;
  assign frame_ok = (cnt == EXP_C) && !par;
`else
  logic unused_sin;
  assign unused_sin = sin;
  assign frame_ok   = (cnt == EXP_C);
`endif

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_err <= 1'b0;
`ifdef PATTERN_BUF_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      frame_err <= err_next;
`ifdef PATTERN_BUF_PARITY_EN
      par       <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = frame_err;
`ifdef PATTERN_BUF_PARITY_EN
    par_next   = par;
`endif
    case (state)
      IDLE: begin
        if (ssel) begin
          state_next = SHIFT;
          cnt_next   = CNT_W'(1);
`ifdef PATTERN_BUF_PARITY_EN
          par_next   = sin;
`endif
        end
      end
      SHIFT: begin
        if (ssel) begin
          cnt_next = cnt_inc;
`ifdef PATTERN_BUF_PARITY_EN
          par_next = par ^ sin;
`endif
          if (cnt_inc == SAT_C) state_next = OVERRUN;
        end else begin
          state_next = IDLE;
          err_next   = !frame_ok;
        end
      end
      OVERRUN: begin
        // Counter stays saturated; bits still pass through for the chain.
        if (!ssel) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_en = ssel;
    commit   = 1'b0;
    if (state == SHIFT && !ssel && frame_ok) commit = 1'b1;
`ifdef PATTERN_BUF_PARITY_EN
    // The trailing parity bit is checked but never enters the shadow bank.
    if (state == SHIFT && cnt == PAY_C) shift_en = 1'b0;
`endif
  end

endmodule

// File: rtl/pattern_buf_dbl.sv
// Double-buffered serial pattern buffer: shadow bank fills serially, active bank is read.
// Build option PATTERN_BUF_PARITY_EN adds a trailing even-parity bit per frame.
module pattern_buf_dbl
  import pattern_buf_pkg::*;
#(
  parameter int BUF_WIDTH = 8,
  parameter int BUF_DEPTH = 32,
  parameter int PTR_W     = $clog2(BUF_DEPTH)
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic                 ssel,
  input  logic                 sin,
  output logic                 sout,
  input  logic [PTR_W-1:0]     fieldp,
  output logic [BUF_WIDTH-1:0] field_byte,
  output logic                 commit,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int FRAME_BITS = calc_frame_bits(BUF_WIDTH, BUF_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);

  logic [BUF_WIDTH-1:0] shadow [BUF_DEPTH];
  logic [BUF_WIDTH-1:0] active [BUF_DEPTH];
  logic                 shift_en;
  state_t               ctl_state;

  pattern_buf_frame_ctl #(
    .FRAME_BITS(FRAME_BITS)
  ) u_ctl (
    .clk      (sclk),
    .rst_n    (rst_n),
    .ssel     (ssel),
    .sin      (sin),
    .shift_en (shift_en),
    .commit   (commit),
    .frame_err(frame_err),
    .state    (ctl_state)
  );

  assign busy = (ctl_state != IDLE);
  assign sout = shadow[BUF_DEPTH-1][BUF_WIDTH-1];

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) shadow[i] <= '0;
    end else if (shift_en) begin
      shadow[0] <= {shadow[0][BUF_WIDTH-2:0], sin};
      for (int i = 1; i < BUF_DEPTH; i++)
        shadow[i] <= {shadow[i][BUF_WIDTH-2:0], shadow[i-1][BUF_WIDTH-1]};
    end
  end

  // The first word received ends up at the shadow tail, so the copy reverses
  // word order to make active[k] the k-th word of the frame.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) active[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < BUF_DEPTH; i++) active[i] <= shadow[BUF_DEPTH-1-i];
    end
  end

  always_comb begin
    field_byte = '0;
    if ({1'b0, fieldp} < DEPTH_C) field_byte = active[fieldp];
  end

endmodule

// File: tb/tb_pattern_buf_dbl.sv
// Directed bench for pattern_buf_dbl with a word scoreboard drained on each commit.
// Default build runs the framing tests; PATTERN_BUF_PARITY_EN runs the parity tests.
module tb_pattern_buf_dbl;
  import pattern_buf_pkg::*;

  localparam int W  = 8;
  localparam int D  = 32;
  localparam int PW = 5;
  localparam int FB = W * D;

  logic          sclk  = 1'b0;
  logic          rst_n = 1'b1;
  logic          ssel  = 1'b0;
  logic          sin   = 1'b0;
  logic [PW-1:0] fieldp = '0;
  logic          sout, commit, frame_err, busy;
  logic [W-1:0]  field_byte;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_active [D];
  logic [W-1:0] words [D];
  logic         stream [0:511];

  pattern_buf_dbl #(
    .BUF_WIDTH(W),
    .BUF_DEPTH(D)
  ) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .ssel      (ssel),
    .sin       (sin),
    .sout      (sout),
    .fieldp    (fieldp),
    .field_byte(field_byte),
    .commit    (commit),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_words();
    for (int k = 0; k < D; k++) words[k] = 8'($urandom_range(0, 255));
  endtask

  task automatic build_stream(input int extra);
    for (int k = 0; k < D; k++)
      for (int b = 0; b < W; b++) stream[k*W + b] = words[k][W-1-b];
    for (int j = FB; j < FB + extra; j++) stream[j] = 1'($urandom_range(0, 1));
  endtask

  task automatic push_expected();
    for (int k = 0; k < D; k++) exp_q.push_back(words[k]);
  endtask

  // Presents n stream bits, one per clock, then leaves ssel low.
  task automatic drive(input int n, input bit long_chk);
    for (int j = 0; j < n; j++) begin
      ssel = 1'b1;
      sin  = stream[j];
      @(negedge sclk);
      if (long_chk && j >= FB) check("sout_chain", sout, stream[j-FB]);
      if (long_chk && j == FB) check("state_at_256", dut.ctl_state, SHIFT);
      if (long_chk && j == FB + 1) check("state_overrun", dut.ctl_state, OVERRUN);
      if (j == n / 2) check("busy_mid", busy, 1);
      @(posedge sclk);
      #1;
    end
    ssel = 1'b0;
    sin  = 1'b0;
  endtask

  task automatic end_frame(input bit good);
    @(negedge sclk);
    check("commit_pulse", commit, good);
    @(posedge sclk);
    #1;
    check("commit_drop", commit, 0);
    check("frame_err", frame_err, !good);
    check("busy_idle", busy, 0);
    if (good) for (int k = 0; k < D; k++) model_active[k] = exp_q.pop_front();
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < D; k++) begin
      fieldp = k[PW-1:0];
      #1;
      check(tag, field_byte, model_active[k]);
    end
    fieldp = '0;
    @(posedge sclk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < D; k++) model_active[k] = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1 rst_n = 1'b1;
    fieldp = 5'd5;
    #1;
    check("rst_field_byte", field_byte, 8'h00);
    check("rst_commit", commit, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_sout", sout, 0);
    check("rst_state", dut.ctl_state, IDLE);
    @(posedge sclk);
    #1;

`ifndef PATTERN_BUF_PARITY_EN
    // Frame A: word k = k + 0x10
    for (int k = 0; k < D; k++) words[k] = 8'(k + 16);
    build_stream(0);
    push_expected();
    drive(FB, 1'b0);
    end_frame(1'b1);
    fieldp = 5'd0;
    #1 check("word0_a", field_byte, 8'h10);
    fieldp = 5'd31;
    #1 check("word31_a", field_byte, 8'h2F);
    sweep("bank_a");

    // Short frame, then a good frame after a single ssel-low cycle
    rand_words();
    build_stream(0);
    fieldp = 5'd0;
    drive(FB - 1, 1'b0);
    end_frame(1'b0);
    check("short_keeps_word0", field_byte, 8'h10);
    rand_words();
    build_stream(0);
    push_expected();
    drive(FB, 1'b0);
    end_frame(1'b1);
    sweep("bank_b");

    // Long frame of 300 bits: overrun, passthrough, no commit
    rand_words();
    build_stream(44);
    drive(FB + 44, 1'b1);
    end_frame(1'b0);
    check("sout_final", sout, stream[44]);
    sweep("bank_long");

    // Reset in the middle of a frame
    rand_words();
    build_stream(0);
    drive(100, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < D; k++) model_active[k] = '0;
    check("midrst_state", dut.ctl_state, IDLE);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sout", sout, 0);
    check("midrst_commit", commit, 0);
    sweep("bank_rst");
    rst_n = 1'b1;
    @(posedge sclk);
    #1;
    rand_words();
    build_stream(0);
    push_expected();
    drive(FB, 1'b0);
    end_frame(1'b1);
    sweep("bank_after_rst");
`else
    // Good parity frame
    rand_words();
    build_stream(0);
    stream[FB] = 1'b0;
    for (int j = 0; j < FB; j++) stream[FB] = stream[FB] ^ stream[j];
    push_expected();
    drive(FB + 1, 1'b0);
    end_frame(1'b1);
    sweep("bank_par_ok");

    // One payload bit flipped: parity mismatch, no commit
    rand_words();
    build_stream(0);
    stream[FB] = 1'b0;
    for (int j = 0; j < FB; j++) stream[FB] = stream[FB] ^ stream[j];
    stream[10] = ~stream[10];
    drive(FB + 1, 1'b0);
    end_frame(1'b0);
    sweep("bank_par_bad");
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
